pci_bus_arbiter: RTL and testbench
==================================

// Module: pci_bus_arbiter
// PURPOSE
//  Round-robin arbiter granting one shared PCI-style bus to NREQ masters via per-master req/gnt pairs.
//  Tracks bus ownership from the shared frame/irdy signals.
//  Issues grant only to an idle bus and parks nothing.
//  Guarantees request->grant in 2..5 clk on an idle bus.
//  Revokes grant the cycle after the owner starts a transaction, or on timeout.
// PARAMETERS
//  NREQ     4   number of requesting masters (2..8)
//  TIMEOUT  16  cycles a grant may sit unused before revocation (>=2)
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst_n        in   1              asynchronous active-low reset
//  req          in   NREQ           per-master request, level, active high
//  frame        in   1              shared bus frame, active high
//  irdy         in   1              shared initiator ready, active high
//  gnt          out  NREQ           per-master grant, registered, one-hot or zero
//  owner_id     out  $clog2(NREQ)   index of last granted master
//  bus_busy     out  1              1 while in BUSY state
//  timeout_err  out  1              1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; gnt=0; owner_id=0; bus_busy=0; timeout_err=0; req_q=0.
//    Round-robin pointer=NREQ-1, so req[0] has highest priority first.
//  - req_q <= req every cycle. Arbitration uses req_q only.
//  - bus_idle = !frame && !irdy, sampled combinationally each cycle.
//  - FSM:
//    IDLE  : |req_q && bus_idle -> ARB; else stay.
//    ARB   : winner = first set bit of req_q scanning ptr+1, ptr+2, ... (mod NREQ).
//            Registers gnt=onehot(winner), owner_id=winner, ptr=winner, tmo_cnt=0 -> GRANT.
//            If req_q==0 or !bus_idle here -> IDLE, gnt stays 0.
//    GRANT : gnt held.
//            frame&&irdy sampled 1 -> BUSY, gnt=0 next cycle.
//            Else req[owner_id]==0 -> IDLE, gnt=0.
//            Else tmo_cnt==TIMEOUT-1 -> IDLE, gnt=0, timeout_err=1 for one cycle.
//            Else tmo_cnt++.
//    BUSY  : bus_busy=1; gnt=0; bus_idle -> IDLE.
//  - Latency: req rises at edge E0 on an idle bus in IDLE -> gnt high after E2.
//    Worst case from IDLE with bus idle is 5 cycles; a busy bus extends this, unbounded by the arbiter.
//  - Priority on simultaneous GRANT events: transaction start > req drop > timeout.
//    If frame&&irdy and req drop occur together, the FSM goes to BUSY.
//  - Pointer wrap: ptr=NREQ-1 scans from 0. Single requester is re-granted repeatedly.
//  - Only one gnt bit is ever high. gnt never high in IDLE/ARB-entry/BUSY. gnt never rises while !bus_idle.
//  - Foreign transaction (frame/irdy activity with no grant) in IDLE: no ARB until bus_idle.
//  - Reset mid-GRANT/BUSY: gnt drops asynchronously. Pointer returns to NREQ-1.
//  - tmo_cnt width $clog2(TIMEOUT); saturating is not needed because the FSM exits at TIMEOUT-1.
// STRUCTURE
//  - pci_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_ARB, ARB_GRANT, ARB_BUSY} arb_state_t;
//    function onehot(idx, n); default NREQ/TIMEOUT localparams.
//  - Sub-module rr_picker (combinational): inputs req_vec, ptr; outputs valid, winner index.
//    Uses a double-width mask-and-priority-encode.
//  - Top holds FSM, req_q, ptr, tmo_cnt, and output registers.
// TESTING
//  - Bind property checks:
//    - rose(req[i]) on idle bus |-> ##[2:5] rose(gnt[i]).
//    - rose(frame&&irdy) while gnt|=> fell(gnt).
//    - $onehot0(gnt).
//    - gnt rises only when bus_idle.
//  T1 reset: rst_n=0 mid-GRANT with gnt=4'b0010 -> gnt=0, owner_id=0, bus_busy=0 immediately.
//  T2 single: req=4'b0100 at E0, bus idle -> gnt=4'b0100 after E2, owner_id=2.
//     frame=irdy=1 at E4 -> gnt=0 after E5, bus_busy=1.
//     frame=irdy=0 -> bus_busy=0 next cycle.
//  T3 round-robin: req=4'b1111 held, each owner completes a 3-cycle transaction ->
//     grant order 0,1,2,3,0; no gnt overlap.
//  T4 timeout (TIMEOUT=16): req=4'b0001, no frame -> gnt high 16 cycles, then gnt=0 and timeout_err pulses once.
//     Next grant goes to the next requester if one is pending.
//  T5 busy bus: frame=1 from foreign master, req=4'b0010 -> gnt stays 0.
//     Release frame/irdy -> gnt=4'b0010 2 cycles later.
//  T6 simultaneous: in GRANT, req[owner] falls in the same cycle frame&&irdy rises -> BUSY, no timeout_err.

Source files
------------

// File: rtl/pci_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin PCI bus arbiter.
package pci_bus_arbiter_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_NREQ    = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ARB,
    ARB_GRANT,
    ARB_BUSY
  } arb_state_t;

  // Returns a vector with only bit idx set; zero when idx falls outside n.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_NREQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      r[i] = (i == idx) && (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Request/grant and shared bus-status signals between the masters and the arbiter.
interface pci_bus_arbiter_if
  import pci_bus_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] req;
  logic            frame;
  logic            irdy;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   owner_id;
  logic            bus_busy;
  logic            timeout_err;

  modport master (
    input  req, frame, irdy,
    output gnt, owner_id, bus_busy, timeout_err
  );

  modport slave (
    output req, frame, irdy,
    input  gnt, owner_id, bus_busy, timeout_err
  );

endinterface

// File: rtl/pci_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping modulo NREQ.
module pci_bus_arbiter_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_vec_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);
  localparam int IW = $clog2(NREQ);
  localparam int DW = IW + 1;

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;
  logic [DW-1:0]     first;

  // Doubling the vector lets a single lowest-bit search cover the wrap-around.
  always_comb begin
    dbl   = {req_vec_i, req_vec_i};
    first = '0;
    for (int i = 0; i < 2*NREQ; i++) begin
      masked[i] = dbl[i] && (DW'(i) > {1'b0, ptr_i});
    end
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (masked[i]) first = DW'(i);
    end
    valid_o  = |req_vec_i;
    winner_o = IW'((first >= DW'(NREQ)) ? (first - DW'(NREQ)) : first);
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: grants only onto an idle bus, revokes on transaction start or timeout.
module pci_bus_arbiter
  import pci_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst_n,
  pci_bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_err_q, tmo_err_d;
  logic            bus_idle;
  logic            xfer_start;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  assign bus_idle   = !bus.frame && !bus.irdy;
  assign xfer_start = bus.frame && bus.irdy;

  pci_bus_arbiter_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_vec_i (req_q),
    .ptr_i     (ptr_q),
    .valid_o   (pick_valid),
    .winner_o  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (|req_q && bus_idle) state_d = ARB_ARB;
      end
      ARB_ARB: begin
        // Requests or bus activity may have changed since IDLE decided to arbitrate.
        if (pick_valid && bus_idle) begin
          gnt_d   = NREQ'(onehot(32'(pick_idx), 32'(NREQ)));
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          tmo_d   = '0;
          state_d = ARB_GRANT;
        end else begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (xfer_start) begin
          gnt_d   = '0;
          state_d = ARB_BUSY;
        end else if (!bus.req[owner_q]) begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end else if (tmo_q == TW'(TIMEOUT-1)) begin
          gnt_d     = '0;
          tmo_err_d = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ARB_BUSY: begin
        gnt_d = '0;
        if (bus_idle) state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= IW'(NREQ-1);
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner_id    = owner_q;
  assign bus.bus_busy    = (state_q == ARB_BUSY);
  assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios plus randomized traffic against a cycle reference model.
module tb_pci_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pci_bus_arbiter_if #(.NREQ(NREQ)) bus();

  pci_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds a grant, whether a foreign/own transfer is on the bus,
  // whether an arbitration is pending, and how long the current grant has been unused.
  logic [NREQ-1:0] m_req_dly;
  bit m_pending, m_holding, m_txn, m_err;
  int m_owner, m_last, m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req_dly = '0;
    m_pending = 0;
    m_holding = 0;
    m_txn     = 0;
    m_err     = 0;
    m_owner   = 0;
    m_last    = NREQ - 1;
    m_age     = 0;
  endtask

  task automatic model_step();
    bit idle;
    bit err;
    idle = !bus.frame && !bus.irdy;
    err  = 0;
    if (m_txn) begin
      if (idle) m_txn = 0;
    end else if (m_holding) begin
      if (bus.frame && bus.irdy) begin
        m_holding = 0;
        m_txn     = 1;
      end else if (!bus.req[m_owner]) begin
        m_holding = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_holding = 0;
        err       = 1;
      end else begin
        m_age++;
      end
    end else if (m_pending) begin
      m_pending = 0;
      if (m_req_dly != 0 && idle) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (m_req_dly[c] && !m_holding) begin
            m_holding = 1;
            m_owner   = c;
          end
        end
        m_last = m_owner;
        m_age  = 0;
      end
    end else if (m_req_dly != 0 && idle) begin
      m_pending = 1;
    end
    m_err     = err;
    m_req_dly = bus.req;
  endtask

  task automatic compare_all();
    chk("gnt", 32'(bus.gnt), m_holding ? (32'd1 << m_owner) : 32'd0);
    chk("owner_id", 32'(bus.owner_id), 32'(m_owner));
    chk("bus_busy", 32'(bus.bus_busy), 32'(m_txn));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_gnt(input string tag);
    int w;
    w = 0;
    while (bus.gnt == '0 && w < 10) begin
      cycle();
      w++;
    end
    if (bus.gnt == '0) chk({tag, "_wait"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, errs, txn_left, frn_left;
    bit lazy;
    bus.req   = '0;
    bus.frame = 1'b0;
    bus.irdy  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_owner", 32'(bus.owner_id), 32'd0);
    chk("rst_busy", 32'(bus.bus_busy), 32'd0);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);

    // Single requester latency, then own transfer with simultaneous req drop.
    bus.req = 4'b0100;
    cycle(); chk("t2_e0", 32'(bus.gnt), 32'd0);
    cycle(); chk("t2_e1", 32'(bus.gnt), 32'd0);
    cycle(); chk("t2_gnt", 32'(bus.gnt), 32'h4);
    chk("t2_owner", 32'(bus.owner_id), 32'd2);
    bus.frame = 1'b1; bus.irdy = 1'b1; bus.req = '0;
    cycle();
    chk("t2_gnt_off", 32'(bus.gnt), 32'd0);
    chk("t2_busy", 32'(bus.bus_busy), 32'd1);
    chk("t6_no_tmo", 32'(bus.timeout_err), 32'd0);
    bus.frame = 1'b0; bus.irdy = 1'b0;
    cycle(); chk("t2_busy_off", 32'(bus.bus_busy), 32'd0);

    // Unused grant times out.
    bus.req = 4'b0001;
    wait_gnt("t4");
    chk("t4_gnt", 32'(bus.gnt), 32'h1);
    cnt = 0; errs = 0;
    while (bus.gnt != '0 && cnt < 40) begin
      cnt++;
      errs += int'(bus.timeout_err);
      cycle();
    end
    errs += int'(bus.timeout_err);
    chk("t4_hold", 32'(cnt), TIMEOUT);
    chk("t4_err_pulses", 32'(errs), 32'd1);
    bus.req = '0;
    repeat (4) cycle();

    // Asynchronous reset while granted.
    bus.req = 4'b0010;
    wait_gnt("t1");
    chk("t1_pre", 32'(bus.gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_owner", 32'(bus.owner_id), 32'd0);
    chk("t1_busy", 32'(bus.bus_busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // All request: rotate 0,1,2,3,0 with a 3-cycle transfer each.
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("t3");
      chk("t3_owner", 32'(bus.owner_id), 32'(k % NREQ));
      chk("t3_gnt", 32'(bus.gnt), 32'd1 << (k % NREQ));
      bus.frame = 1'b1; bus.irdy = 1'b1;
      repeat (3) cycle();
      bus.frame = 1'b0; bus.irdy = 1'b0;
      cycle();
    end
    bus.req = '0;
    repeat (4) cycle();

    // Foreign transfer holds off the grant.
    bus.frame = 1'b1; bus.req = 4'b0010;
    repeat (6) cycle();
    chk("t5_held", 32'(bus.gnt), 32'd0);
    bus.frame = 1'b0; bus.irdy = 1'b0;
    cycle(); chk("t5_e1", 32'(bus.gnt), 32'd0);
    cycle(); chk("t5_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    repeat (4) cycle();

    // Randomized traffic.
    txn_left = 0; frn_left = 0; lazy = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) lazy = ($urandom_range(0, 2) == 0);
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, lazy ? 63 : 15) == 0) bus.req[i] = ~bus.req[i];
      end
      if (txn_left > 0) begin
        bus.frame = 1'b1; bus.irdy = 1'b1;
        txn_left--;
      end else if (frn_left > 0) begin
        bus.frame = 1'b1; bus.irdy = 1'($urandom_range(0, 1));
        frn_left--;
      end else begin
        bus.frame = 1'b0; bus.irdy = 1'b0;
        if (m_holding && !lazy && $urandom_range(0, 5) == 0) begin
          txn_left = int'($urandom_range(0, 3));
          bus.frame = 1'b1; bus.irdy = 1'b1;
        end else if (!m_holding && !m_txn && $urandom_range(0, 29) == 0) begin
          frn_left = int'($urandom_range(1, 5));
        end
      end
    end
    bus.req = '0; bus.frame = 1'b0; bus.irdy = 1'b0;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
